// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle, forwarding and data-SRAM signals of the execute stage.
// master drives the decode bundle; slave is the execute stage itself.
interface ex_stage_if;
    logic [163:0] id_to_ex_bus;
    logic [80:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         ex_ram_read;
    logic         stallreq_for_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    modport master (
        output id_to_ex_bus,
        input  ex_to_mem_bus,
        input  ex_to_rf_bus,
        input  ex_ram_read,
        input  stallreq_for_ex,
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata
    );

    modport slave (
        input  id_to_ex_bus,
        output ex_to_mem_bus,
        output ex_to_rf_bus,
        output ex_ram_read,
        output stallreq_for_ex,
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage - pipeline register, ALU, data-SRAM request.
// Optional iterative divider with HI/LO (mfhi/mflo) built when EX_DIV_EN is defined.
module ex_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] stall,
    ex_stage_if.slave  bus
);

    logic [163:0] r_bus;

    logic [4:0]  w_mem_op;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel1;
    logic [3:0]  w_sel2;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic        w_sel_rf_res;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;

    // Pipeline register: clear, bubble when decode stops alone, load, or hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bus <= '0;
        end else if (stall[2] && !stall[3]) begin
            r_bus <= '0;
        end else if (!stall[2]) begin
            r_bus <= bus.id_to_ex_bus;
        end
    end

    assign w_mem_op     = r_bus[163:159];
    assign w_pc         = r_bus[158:127];
    assign w_inst       = r_bus[126:95];
    assign w_alu_op     = r_bus[94:83];
    assign w_sel1       = r_bus[82:80];
    assign w_sel2       = r_bus[79:76];
    assign w_ram_en     = r_bus[75];
    assign w_ram_wen    = r_bus[74:71];
    assign w_rf_we      = r_bus[70];
    assign w_rf_waddr   = r_bus[69:65];
    assign w_sel_rf_res = r_bus[64];
    assign w_rdata1     = r_bus[63:32];
    assign w_rdata2     = r_bus[31:0];

    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;
    logic [31:0] w_sa;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [4:0]  w_shamt;

    assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};
    assign w_imm_zext = {16'b0, w_inst[15:0]};
    assign w_sa       = {27'b0, w_inst[10:6]};

    // Operand selects are one-hot; an empty select yields zero
    always_comb begin
        w_src1 = ({32{w_sel1[0]}} & w_rdata1)
               | ({32{w_sel1[1]}} & w_pc)
               | ({32{w_sel1[2]}} & w_sa);
        w_src2 = ({32{w_sel2[0]}} & w_rdata2)
               | ({32{w_sel2[1]}} & w_imm_sext)
               | ({32{w_sel2[2]}} & 32'd8)
               | ({32{w_sel2[3]}} & w_imm_zext);
    end

    assign w_shamt = w_src1[4:0];

    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic [31:0] w_slt;
    logic [31:0] w_sltu;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_lui;
    logic [31:0] w_alu_res;

    assign w_add  = w_src1 + w_src2;
    assign w_sub  = w_src1 - w_src2;
    assign w_slt  = {31'b0, $signed(w_src1) < $signed(w_src2)};
    assign w_sltu = {31'b0, w_src1 < w_src2};
    assign w_sll  = w_src2 << w_shamt;
    assign w_srl  = w_src2 >> w_shamt;
    assign w_sra  = $unsigned($signed(w_src2) >>> w_shamt);
    assign w_lui  = {w_src2[15:0], 16'b0};

    // ALU result: one-hot op select, all-zero op gives zero
    always_comb begin
        w_alu_res = ({32{w_alu_op[11]}} & w_add)
                  | ({32{w_alu_op[10]}} & w_sub)
                  | ({32{w_alu_op[9]}}  & w_slt)
                  | ({32{w_alu_op[8]}}  & w_sltu)
                  | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                  | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                  | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                  | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                  | ({32{w_alu_op[3]}}  & w_sll)
                  | ({32{w_alu_op[2]}}  & w_srl)
                  | ({32{w_alu_op[1]}}  & w_sra)
                  | ({32{w_alu_op[0]}}  & w_lui);
    end

    logic [31:0] w_ex_result;
    logic        w_rf_we_o;
    logic [4:0]  w_rf_waddr_o;
    logic        w_stallreq;

`ifdef EX_DIV_EN

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    div_state_t r_state;
    div_state_t w_next;

    logic        w_special;
    logic        w_is_div;
    logic        w_is_signed;
    logic        w_is_mfhi;
    logic        w_is_mflo;

    assign w_special   = (w_inst[31:26] == 6'd0);
    assign w_is_signed = (w_inst[5:0] == 6'h1A);
    assign w_is_div    = w_special && (w_is_signed || (w_inst[5:0] == 6'h1B));
    assign w_is_mfhi   = w_special && (w_inst[5:0] == 6'h10);
    assign w_is_mflo   = w_special && (w_inst[5:0] == 6'h12);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic [31:0] r_d;
    logic [31:0] r_a_raw;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;

    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_trial;
    logic [31:0] w_hi_fin;
    logic [31:0] w_lo_fin;

    assign w_abs1 = (w_is_signed && w_rdata1[31]) ? -w_rdata1 : w_rdata1;
    assign w_abs2 = (w_is_signed && w_rdata2[31]) ? -w_rdata2 : w_rdata2;

    // Restoring step: shift next dividend bit into the partial remainder
    assign w_trial = {r_r, r_q[31]} - {1'b0, r_d};

    assign w_lo_fin = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? -r_q : r_q);
    assign w_hi_fin = r_dz ? r_a_raw : (r_neg_r ? -r_r : r_r);

    // Divider state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Divider next state; DONE waits for execute to advance so the
    // held divide is not restarted
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_is_div) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == 5'd31) w_next = S_DONE;
            S_DONE:  if (!stall[3]) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Divider stall request
    always_comb begin
        w_stallreq = 1'b0;
        case (r_state)
            S_IDLE:  w_stallreq = w_is_div;
            S_BUSY:  w_stallreq = 1'b1;
            default: w_stallreq = 1'b0;
        endcase
    end

    // Divider datapath and HI/LO write-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_a_raw <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_div) begin
                        r_q     <= w_abs1;
                        r_r     <= '0;
                        r_d     <= w_abs2;
                        r_a_raw <= w_rdata1;
                        r_cnt   <= '0;
                        r_neg_q <= w_is_signed && (w_rdata1[31] ^ w_rdata2[31]);
                        r_neg_r <= w_is_signed && w_rdata1[31];
                        r_dz    <= (w_rdata2 == 32'd0);
                    end
                end
                S_BUSY: begin
                    if (!w_trial[32]) begin
                        r_r <= w_trial[31:0];
                        r_q <= {r_q[30:0], 1'b1};
                    end else begin
                        r_r <= {r_r[30:0], r_q[31]};
                        r_q <= {r_q[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DONE: begin
                    r_hi <= w_hi_fin;
                    r_lo <= w_lo_fin;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // mfhi/mflo write rd with HI/LO; everything else takes the ALU result
    always_comb begin
        w_ex_result  = w_alu_res;
        w_rf_we_o    = w_rf_we;
        w_rf_waddr_o = w_rf_waddr;
        if (w_is_mfhi) begin
            w_ex_result  = r_hi;
            w_rf_we_o    = 1'b1;
            w_rf_waddr_o = w_inst[15:11];
        end else if (w_is_mflo) begin
            w_ex_result  = r_lo;
            w_rf_we_o    = 1'b1;
            w_rf_waddr_o = w_inst[15:11];
        end
    end

`else

    assign w_stallreq   = 1'b0;
    assign w_ex_result  = w_alu_res;
    assign w_rf_we_o    = w_rf_we;
    assign w_rf_waddr_o = w_rf_waddr;

`endif

    // Bits not consumed in every build configuration
    logic w_unused;
    assign w_unused = ^{stall, w_inst[31:16], w_inst[5:0]};

    assign bus.ex_to_mem_bus = {
        w_mem_op,
        w_pc,
        w_ram_en,
        w_ram_wen,
        w_sel_rf_res,
        w_rf_we_o,
        w_rf_waddr_o,
        w_ex_result
    };

    assign bus.ex_to_rf_bus = {w_rf_we_o, w_rf_waddr_o, w_ex_result};

    assign bus.ex_ram_read     = w_ram_en & ~w_ram_wen[0];
    assign bus.stallreq_for_ex = w_stallreq;
    assign bus.data_sram_en    = w_ram_en;
    assign bus.data_sram_wen   = (w_ram_en && w_ram_wen[0]) ? 4'b1111 : 4'b0000;
    assign bus.data_sram_addr  = w_alu_res;
    assign bus.data_sram_wdata = w_rdata2;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of the decode stage. Latches the decode bundle into its pipeline register and computes the ALU result. Issues the data-SRAM request, sends forwarding data back to decode, and passes a bundle on to the memory stage. Optionally holds an iterative divider with HI/LO registers, which stalls the pipeline while it runs.

## Interface
- ID_TO_EX_WD, 164: width of the decode bundle, fixed by `lib/defines.vh`.
- EX_TO_MEM_WD, 81: width of the outgoing memory-stage bundle.
- EX_TO_RF_WD, 38: width of the forwarding bundle.
- StallBus, 6: width of the stall vector.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  StallBus  stage stall vector; stall[2] stops decode, stall[3] stops execute.
- id_to_ex_bus  in  164  decode bundle, fields from MSB down:
  - mem_op[163:159], pc[158:127], inst[126:95], alu_op[94:83].
  - sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71].
  - rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0].
- ex_to_mem_bus  out  81  {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
- ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result}, fed back to decode for forwarding.
- ex_ram_read  out  1  high when the instruction in execute is a load.
- stallreq_for_ex  out  1  divider busy; holds stages 0..3.
- data_sram_en  out  1  data SRAM enable.
- data_sram_wen  out  4  data SRAM byte write enables.
- data_sram_addr  out  32  data SRAM address.
- data_sram_wdata  out  32  data SRAM write data.

## Operation
Pipeline register (the bundle latched from id_to_ex_bus; all its fields are called "latched" below):
- `!rst_n`: register cleared to 0.
- stall[2]=Stop and stall[3]=NoStop: register loads 0 (bubble).
- stall[2]=NoStop: register loads id_to_ex_bus.
- Otherwise: register holds.

ALU operand 1, one-hot select:
- sel_alu_src1[0] selects rdata1.
- sel_alu_src1[1] selects pc.
- sel_alu_src1[2] selects {27'b0, inst[10:6]}.
- No bit set gives 0.

ALU operand 2, one-hot select:
- sel_alu_src2[0] selects rdata2.
- sel_alu_src2[1] selects the sign-extended inst[15:0].
- sel_alu_src2[2] selects 32'd8.
- sel_alu_src2[3] selects the zero-extended inst[15:0].
- No bit set gives 0.

ALU operations. alu_op bit order, bit 11 down to bit 0: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- add and sub are modulo 2^32; there is no overflow trap.
- slt compares signed and gives 1 or 0; sltu compares unsigned.
- Shifts shift operand 2 by operand 1 [4:0]; sra is arithmetic.
- lui gives {operand 2 [15:0], 16'b0}.
- alu_op all zero gives result 0.

Data SRAM request:
- data_sram_en = latched data_ram_en.
- data_sram_wen = 4'b1111 when data_ram_en and data_ram_wen[0], else 4'b0000.
- data_sram_addr = ALU result.
- data_sram_wdata = rdata2.

ex_ram_read = data_ram_en & ~data_ram_wen[0].

ex_result is the ALU result, except for mfhi/mflo when DIV_EN is compiled in (see Configuration).

## Timing
- Combinational from the pipeline register to all outputs; the stage itself adds one cycle of latency.
- Values after reset:
  - All outputs are 0.
  - stallreq_for_ex is 0.
  - HI and LO are 0.
  - The divider FSM is in IDLE.
- A synchronous reset asserted mid-divide aborts the divide: stallreq_for_ex drops on the next edge and HI/LO are not written.

Divider FSM (DIV_EN only). A div is recognised when inst[31:26]=0 and inst[5:0] is 6'h1A (div, signed) or 6'h1B (divu).
- IDLE:
  - Divide in the register: stallreq_for_ex=1 combinationally.
  - At the edge: latch the operand magnitudes (signed for div, raw for divu), cnt←0, go to BUSY.
- BUSY:
  - stallreq_for_ex=1.
  - One restoring-division step per cycle.
  - At cnt=31: go to DONE.
- DONE:
  - stallreq_for_ex=0.
  - Write HI←remainder and LO←quotient at the edge.
  - Sign fix-up for div: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - Leave for IDLE only when stall[3]=NoStop; otherwise stay in DONE, so the held divide is not restarted.
- stallreq_for_ex is high for exactly 33 consecutive cycles per divide.
- Divisor 0: LO=32'hFFFF_FFFF, HI=rdata1, and the sign fix-up is skipped.

## Configuration
- Macro: `EX_DIV_EN`.
- Defined:
  - The divider FSM, HI/LO registers and stallreq_for_ex are built.
  - mfhi (funct 6'h10) and mflo (funct 6'h12) force rf_we=1 and rf_waddr=inst[15:11] on both outgoing buses.
  - For these two instructions ex_result is HI or LO.
  - HI/LO values written at the DONE edge are visible to an mfhi/mflo in execute on the next cycle.
- Undefined:
  - stallreq_for_ex is tied to 0.
  - div, divu, mfhi and mflo pass through as no-ops that use the ALU result.

## Test plan
- Reset low for 2 cycles, then load addiu with rdata1=5, imm=16'hFFFF → ex_result=4, rf_we=1, waddr=rt.
- sw with rdata1=0x1000, imm=8, rdata2=0xDEADBEEF → data_sram_en=1, wen=4'hF, addr=0x1008, wdata=0xDEADBEEF, ex_ram_read=0.
- lw issued → ex_ram_read=1 and wen=0; then stall[2]=Stop with stall[3]=NoStop → the next cycle carries an all-zero bubble.
- EX_DIV_EN: div with rdata1=-7, rdata2=2 → stallreq_for_ex high for exactly 33 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFD; a following mflo gives ex_result=0xFFFFFFFD.
- EX_DIV_EN: divu with rdata2=0 → LO=0xFFFFFFFF, HI=rdata1.
- EX_DIV_EN: rst_n low at BUSY cycle 10 → stallreq_for_ex=0 the next cycle and HI=LO=0.
